// File: rtl/mem_bus_arbiter.sv
// Shares one single-port synchronous RAM between the fetch and data ports of the core.
// Optional macro ARB_ROUND_ROBIN_EN: alternate grants when both ports contend (default: data wins).
module mem_bus_arbiter #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inst_req,
    input  logic [ADDR_W-1:0] inst_addr,
    output logic [DATA_W-1:0] inst_rdata,
    output logic              inst_ready,
    input  logic              data_req,
    input  logic [3:0]        data_wen,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [DATA_W-1:0] data_wdata,
    output logic [DATA_W-1:0] data_rdata,
    output logic              data_ready,
    output logic              stall_inst,
    output logic              stall_data,
    output logic              mem_en,
    output logic [3:0]        mem_wen,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

    localparam logic GRANT_INST = 1'b0;
    localparam logic GRANT_DATA = 1'b1;

    state_t            state_q;
    logic              owner_q;
    logic              last_grant_q;
    logic [3:0]        cnt_q;
    logic              mem_en_q;
    logic [3:0]        mem_wen_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;
    logic [DATA_W-1:0] inst_rdata_q;
    logic [DATA_W-1:0] data_rdata_q;
    logic              inst_ready_q;
    logic              data_ready_q;

    logic              grant_data_d;

`ifdef ARB_ROUND_ROBIN_EN
    // Under contention the port that did not win last time goes first.
    assign grant_data_d = data_req & (~inst_req | (last_grant_q == GRANT_INST));
`else
    logic unused_last_grant;
    assign unused_last_grant = last_grant_q;
    assign grant_data_d      = data_req;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            owner_q      <= GRANT_INST;
            last_grant_q <= GRANT_INST;
            cnt_q        <= 4'd0;
            mem_en_q     <= 1'b0;
            mem_wen_q    <= 4'd0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            inst_rdata_q <= '0;
            data_rdata_q <= '0;
            inst_ready_q <= 1'b0;
            data_ready_q <= 1'b0;
        end else begin
            mem_en_q     <= 1'b0;
            inst_ready_q <= 1'b0;
            data_ready_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (inst_req | data_req) begin
                        owner_q     <= grant_data_d;
                        mem_en_q    <= 1'b1;
                        mem_addr_q  <= grant_data_d ? data_addr  : inst_addr;
                        mem_wen_q   <= grant_data_d ? data_wen   : 4'd0;
                        mem_wdata_q <= grant_data_d ? data_wdata : '0;
                        cnt_q       <= 4'(WAIT_CYCLES);
                        state_q     <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    // cnt_q hits zero exactly when the RAM response is on mem_rdata.
                    if (cnt_q == 4'd0) begin
                        if (owner_q == GRANT_INST) begin
                            inst_rdata_q <= mem_rdata;
                            inst_ready_q <= 1'b1;
                        end else begin
                            if (mem_wen_q == 4'd0) begin
                                data_rdata_q <= mem_rdata;
                            end
                            data_ready_q <= 1'b1;
                        end
                        state_q <= S_DONE;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                S_DONE: begin
                    last_grant_q <= owner_q;
                    state_q      <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign mem_en     = mem_en_q;
    assign mem_wen    = mem_wen_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign inst_rdata = inst_rdata_q;
    assign data_rdata = data_rdata_q;
    assign inst_ready = inst_ready_q;
    assign data_ready = data_ready_q;

    // A requester stays stalled until its own ready pulse is seen.
    assign stall_inst = inst_req & ~inst_ready_q;
    assign stall_data = data_req & ~data_ready_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter with a latency-accurate RAM model and scoreboard.
// Expected grant order follows ARB_ROUND_ROBIN_EN when it is defined.
module tb_mem_bus_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int WC = 2;

    logic          clk        = 1'b0;
    logic          rst        = 1'b1;
    logic          inst_req   = 1'b0;
    logic [AW-1:0] inst_addr  = '0;
    logic [DW-1:0] inst_rdata;
    logic          inst_ready;
    logic          data_req   = 1'b0;
    logic [3:0]    data_wen   = '0;
    logic [AW-1:0] data_addr  = '0;
    logic [DW-1:0] data_wdata = '0;
    logic [DW-1:0] data_rdata;
    logic          data_ready;
    logic          stall_inst;
    logic          stall_data;
    logic          mem_en;
    logic [3:0]    mem_wen;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int overlap_cnt = 0;

    typedef struct {
        bit          port;
        logic [3:0]  wen;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
    } exp_t;

    typedef struct {
        int          cyc;
        logic [3:0]  wen;
        logic [31:0] addr;
        logic [31:0] wdata;
    } cmd_t;

    typedef struct {
        int          cyc;
        bit          port;
        logic [31:0] rdata;
    } rdy_t;

    exp_t exp_q[$];
    cmd_t cmd_log[$];
    rdy_t rdy_log[$];

    mem_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(WC)) dut (
        .clk        (clk),
        .rst        (rst),
        .inst_req   (inst_req),
        .inst_addr  (inst_addr),
        .inst_rdata (inst_rdata),
        .inst_ready (inst_ready),
        .data_req   (data_req),
        .data_wen   (data_wen),
        .data_addr  (data_addr),
        .data_wdata (data_wdata),
        .data_rdata (data_rdata),
        .data_ready (data_ready),
        .stall_inst (stall_inst),
        .stall_data (stall_data),
        .mem_en     (mem_en),
        .mem_wen    (mem_wen),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // RAM model: word-addressed, byte writes, read data valid WC cycles after mem_en.
    logic [31:0] mem [256];
    logic [31:0] pipe_data [WC];
    bit          pipe_vld  [WC];

    function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old_w;
        for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = new_w[8*b +: 8];
        return r;
    endfunction

    always @(posedge clk) begin
        if (!rst) begin
            mem[8'h10] <= 32'h8C080004;
            mem[8'h40] <= 32'hDEADBEEF;
            mem[8'h41] <= 32'hAAAAAAAA;
            mem[8'h80] <= 32'h11112222;
            mem[8'hC0] <= 32'h33334444;
            mem[8'hFF] <= 32'h55555555;
        end else if (mem_en && mem_wen != 4'b0) begin
            mem[mem_addr[9:2]] <= merge(mem[mem_addr[9:2]], mem_wdata, mem_wen);
        end
    end

    always @(posedge clk) begin
        pipe_vld[0]  <= mem_en;
        pipe_data[0] <= mem[mem_addr[9:2]];
        for (int k = 1; k < WC; k++) begin
            pipe_vld[k]  <= pipe_vld[k-1];
            pipe_data[k] <= pipe_data[k-1];
        end
    end

    assign mem_rdata = pipe_vld[WC-1] ? pipe_data[WC-1] : 32'hBADBAD00;

    always @(negedge clk) begin
        if (mem_en) cmd_log.push_back('{cyc, mem_wen, mem_addr, mem_wdata});
        if (inst_ready) rdy_log.push_back('{cyc, 1'b0, inst_rdata});
        if (data_ready) rdy_log.push_back('{cyc, 1'b1, data_rdata});
        if (inst_ready && data_ready) overlap_cnt <= overlap_cnt + 1;
    end

    task automatic test_reset();
        #2 rst = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if ({mem_en, mem_wen, inst_ready, data_ready, stall_inst, stall_data} !== 10'b0) begin
            failures++;
            $display("FAIL reset_ctrl en=%b wen=%b irdy=%b drdy=%b si=%b sd=%b required all 0",
                     mem_en, mem_wen, inst_ready, data_ready, stall_inst, stall_data);
        end
        checks++;
        if (mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin
            failures++;
            $display("FAIL reset_bus addr=%h wdata=%h required 0", mem_addr, mem_wdata);
        end
        checks++;
        if (inst_rdata !== 32'h0 || data_rdata !== 32'h0) begin
            failures++;
            $display("FAIL reset_rdata inst=%h data=%h required 0", inst_rdata, data_rdata);
        end
        rst = 1'b1;
        cmd_log.delete();
        rdy_log.delete();
        repeat (4) @(negedge clk);
        #1;
        checks++;
        if (cmd_log.size() != 0 || rdy_log.size() != 0) begin
            failures++;
            $display("FAIL reset_idle cmds=%0d readies=%0d required 0", cmd_log.size(), rdy_log.size());
        end
    endtask

    // Fetch, load, store in sequence; each one alone on the bus.
    task automatic test_single();
        exp_t        tbl [3];
        logic [31:0] other_exp [3];
        tbl[0] = '{1'b0, 4'b0000, 32'h00000040, 32'h00000000, 32'h8C080004};
        tbl[1] = '{1'b1, 4'b0000, 32'h00000100, 32'hCAFEF00D, 32'hDEADBEEF};
        tbl[2] = '{1'b1, 4'b0011, 32'h00000104, 32'h12345678, 32'hDEADBEEF};
        other_exp[0] = 32'h0;
        other_exp[1] = 32'h8C080004;
        other_exp[2] = 32'h8C080004;
        for (int i = 0; i < 3; i++) begin
            exp_t e;
            cmd_t c;
            rdy_t r;
            int   c0;
            int   stall_n;
            bit   ok;
            exp_q.push_back(tbl[i]);
            cmd_log.delete();
            rdy_log.delete();
            c0 = cyc;
            if (tbl[i].port) begin
                data_req = 1'b1; data_wen = tbl[i].wen;
                data_addr = tbl[i].addr; data_wdata = tbl[i].wdata;
            end else begin
                inst_req = 1'b1; inst_addr = tbl[i].addr;
            end
            stall_n = 0;
            ok = 1'b0;
            for (int k = 0; k < 20 && !ok; k++) begin
                #1;
                if (tbl[i].port ? data_ready : inst_ready) ok = 1'b1;
                else begin
                    if (tbl[i].port ? stall_data : stall_inst) stall_n++;
                    if (k == 1) begin inst_addr = 32'hFFC; data_addr = 32'hFFC; end
                    @(negedge clk);
                end
            end
            inst_req = 1'b0;
            data_req = 1'b0;
            e = exp_q.pop_front();
            checks++;
            if (!ok) begin
                failures++;
                $display("FAIL single[%0d]_timeout ready=0 required 1 within 20 cycles", i);
            end
            checks++;
            if (stall_n != WC + 2) begin
                failures++;
                $display("FAIL single[%0d]_stall cycles=%0d required %0d", i, stall_n, WC + 2);
            end
            checks++;
            if (cmd_log.size() != 1 || rdy_log.size() != 1) begin
                failures++;
                $display("FAIL single[%0d]_count cmds=%0d readies=%0d required 1", i,
                         cmd_log.size(), rdy_log.size());
            end else begin
                c = cmd_log.pop_front();
                r = rdy_log.pop_front();
                checks++;
                if (c.cyc != c0 + 1 || c.addr !== e.addr || c.wen !== e.wen ||
                    (e.wen != 4'b0 && c.wdata !== e.wdata)) begin
                    failures++;
                    $display("FAIL single[%0d]_cmd cyc=%0d addr=%h wen=%b wdata=%h required cyc=%0d addr=%h wen=%b wdata=%h",
                             i, c.cyc, c.addr, c.wen, c.wdata, c0 + 1, e.addr, e.wen, e.wdata);
                end
                checks++;
                if (r.cyc != c0 + WC + 2 || r.port != e.port || r.rdata !== e.rdata) begin
                    failures++;
                    $display("FAIL single[%0d]_ready cyc=%0d port=%0d rdata=%h required cyc=%0d port=%0d rdata=%h",
                             i, r.cyc, r.port, r.rdata, c0 + WC + 2, e.port, e.rdata);
                end
            end
            checks++;
            if ((e.port ? inst_rdata : data_rdata) !== other_exp[i]) begin
                failures++;
                $display("FAIL single[%0d]_other_rdata got=%h required %h", i,
                         e.port ? inst_rdata : data_rdata, other_exp[i]);
            end
            @(negedge clk);
            #1;
        end
    endtask

    task automatic test_reset_mid();
        exp_t e;
        rdy_t r;
        int   c0;
        bit   ok;
        cmd_log.delete();
        rdy_log.delete();
        data_req = 1'b1; data_wen = 4'b0; data_addr = 32'h100;
        ok = 1'b0;
        for (int k = 0; k < 10 && !ok; k++) begin
            @(negedge clk);
            #1;
            if (cmd_log.size() > 0) ok = 1'b1;
        end
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL rstmid_grant mem_en=0 required 1 within 10 cycles");
        end
        rst = 1'b0;
        data_req = 1'b0;
        #1;
        checks++;
        if ({mem_en, mem_wen, inst_ready, data_ready, stall_inst, stall_data} !== 10'b0 ||
            mem_addr !== 32'h0 || mem_wdata !== 32'h0 || inst_rdata !== 32'h0 || data_rdata !== 32'h0) begin
            failures++;
            $display("FAIL rstmid_outputs en=%b wen=%b addr=%h wdata=%h irdy=%b drdy=%b ird=%h drd=%h required all 0",
                     mem_en, mem_wen, mem_addr, mem_wdata, inst_ready, data_ready, inst_rdata, data_rdata);
        end
        repeat (2) @(negedge clk);
        #1;
        rst = 1'b1;
        cmd_log.delete();
        rdy_log.delete();
        repeat (8) @(negedge clk);
        #1;
        checks++;
        if (cmd_log.size() != 0 || rdy_log.size() != 0) begin
            failures++;
            $display("FAIL rstmid_quiet cmds=%0d readies=%0d required 0", cmd_log.size(), rdy_log.size());
        end
        exp_q.push_back('{1'b0, 4'b0, 32'h40, 32'h0, 32'h8C080004});
        c0 = cyc;
        inst_req = 1'b1; inst_addr = 32'h40;
        ok = 1'b0;
        for (int k = 0; k < 20 && !ok; k++) begin
            #1;
            if (inst_ready) ok = 1'b1;
            else @(negedge clk);
        end
        inst_req = 1'b0;
        e = exp_q.pop_front();
        checks++;
        if (!ok || rdy_log.size() != 1) begin
            failures++;
            $display("FAIL rstmid_fetch_done ready_seen=%0d readies=%0d required 1", ok, rdy_log.size());
        end else begin
            r = rdy_log.pop_front();
            checks++;
            if (r.cyc != c0 + WC + 2 || r.port != e.port || r.rdata !== e.rdata) begin
                failures++;
                $display("FAIL rstmid_fetch cyc=%0d port=%0d rdata=%h required cyc=%0d port=%0d rdata=%h",
                         r.cyc, r.port, r.rdata, c0 + WC + 2, e.port, e.rdata);
            end
        end
        @(negedge clk);
        #1;
    endtask

    // Both ports request together; each drops its request on its own ready.
    task automatic test_both();
        int c0;
        bit ok;
        cmd_log.delete();
        rdy_log.delete();
        exp_q.push_back('{1'b1, 4'b0, 32'h100, 32'h0, 32'hDEADBEEF});
        exp_q.push_back('{1'b0, 4'b0, 32'h40, 32'h0, 32'h8C080004});
        c0 = cyc;
        data_req = 1'b1; data_wen = 4'b0; data_addr = 32'h100; data_wdata = 32'hCAFEF00D;
        inst_req = 1'b1; inst_addr = 32'h40;
        ok = 1'b0;
        for (int k = 0; k < 30 && !ok; k++) begin
            @(negedge clk);
            #1;
            if (inst_ready) inst_req = 1'b0;
            if (data_ready) data_req = 1'b0;
            if (!inst_req && !data_req) ok = 1'b1;
        end
        inst_req = 1'b0;
        data_req = 1'b0;
        checks++;
        if (!ok || cmd_log.size() != 2 || rdy_log.size() != 2) begin
            failures++;
            $display("FAIL both_count done=%0d cmds=%0d readies=%0d required 2", ok,
                     cmd_log.size(), rdy_log.size());
            exp_q.delete();
        end else begin
            for (int i = 0; i < 2; i++) begin
                exp_t e;
                cmd_t c;
                rdy_t r;
                e = exp_q.pop_front();
                c = cmd_log.pop_front();
                r = rdy_log.pop_front();
                checks++;
                if (c.cyc != c0 + 1 + (WC + 3) * i || c.addr !== e.addr || c.wen !== e.wen) begin
                    failures++;
                    $display("FAIL both_cmd[%0d] cyc=%0d addr=%h wen=%b required cyc=%0d addr=%h wen=%b",
                             i, c.cyc, c.addr, c.wen, c0 + 1 + (WC + 3) * i, e.addr, e.wen);
                end
                checks++;
                if (r.cyc != c0 + WC + 2 + (WC + 3) * i || r.port != e.port || r.rdata !== e.rdata) begin
                    failures++;
                    $display("FAIL both_ready[%0d] cyc=%0d port=%0d rdata=%h required cyc=%0d port=%0d rdata=%h",
                             i, r.cyc, r.port, r.rdata, c0 + WC + 2 + (WC + 3) * i, e.port, e.rdata);
                end
            end
        end
        checks++;
        if (overlap_cnt != 0) begin
            failures++;
            $display("FAIL both_overlap cycles_with_two_readies=%0d required 0", overlap_cnt);
        end
        @(negedge clk);
        #1;
    endtask

    // Both ports held through three grants, then dropped mid-access.
    task automatic test_held();
        exp_t d_e;
        exp_t i_e;
        int   c0;
        bit   ok;
        d_e = '{1'b1, 4'b0, 32'h300, 32'h0, 32'h33334444};
        i_e = '{1'b0, 4'b0, 32'h200, 32'h0, 32'h11112222};
        cmd_log.delete();
        rdy_log.delete();
`ifdef ARB_ROUND_ROBIN_EN
        exp_q.push_back(d_e); exp_q.push_back(i_e); exp_q.push_back(d_e);
`else
        exp_q.push_back(d_e); exp_q.push_back(d_e); exp_q.push_back(d_e);
`endif
        c0 = cyc;
        data_req = 1'b1; data_wen = 4'b0; data_addr = 32'h300; data_wdata = 32'hCAFEF00D;
        inst_req = 1'b1; inst_addr = 32'h200;
        ok = 1'b0;
        for (int k = 0; k < 40 && !ok; k++) begin
            @(negedge clk);
            #1;
            if (cmd_log.size() >= 3) ok = 1'b1;
        end
        data_req = 1'b0;
        inst_req = 1'b0;
        ok = 1'b0;
        for (int k = 0; k < 20 && !ok; k++) begin
            @(negedge clk);
            #1;
            if (rdy_log.size() >= 3) ok = 1'b1;
        end
        checks++;
        if (!ok || cmd_log.size() != 3 || rdy_log.size() != 3) begin
            failures++;
            $display("FAIL held_count done=%0d cmds=%0d readies=%0d required 3", ok,
                     cmd_log.size(), rdy_log.size());
            exp_q.delete();
        end else begin
            for (int i = 0; i < 3; i++) begin
                exp_t e;
                cmd_t c;
                rdy_t r;
                e = exp_q.pop_front();
                c = cmd_log.pop_front();
                r = rdy_log.pop_front();
                checks++;
                if (c.cyc != c0 + 1 + (WC + 3) * i || c.addr !== e.addr) begin
                    failures++;
                    $display("FAIL held_cmd[%0d] cyc=%0d addr=%h required cyc=%0d addr=%h",
                             i, c.cyc, c.addr, c0 + 1 + (WC + 3) * i, e.addr);
                end
                checks++;
                if (r.port != e.port || r.rdata !== e.rdata) begin
                    failures++;
                    $display("FAIL held_ready[%0d] port=%0d rdata=%h required port=%0d rdata=%h",
                             i, r.port, r.rdata, e.port, e.rdata);
                end
            end
        end
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (cmd_log.size() != 0 || overlap_cnt != 0) begin
            failures++;
            $display("FAIL held_after_drop extra_cmds=%0d overlaps=%0d required 0", cmd_log.size(), overlap_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_reset_mid();
        test_both();
        test_held();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
